imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the single-cycle core's instruction memory. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake and assembles 32-bit words. Each word goes to the instruction memory write port at consecutive word addresses from 0. It holds the core in reset until the image is fully written, so it is the writer that pairs with the core's read-only fetch path.

## Interface
- `MAX_WORDS`, default 1024: instruction memory depth in words; the largest legal image length.
- `ADDR_W`, default 32: width of the byte address on the write port.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load; ignored unless in IDLE.
- `byte_valid` in 1: source has a byte.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle; a transfer occurs when `byte_valid && byte_ready`.
- `imem_we` out 1: write strobe, one cycle per word.
- `imem_waddr` out ADDR_W: byte address, always word-aligned (bits [1:0] = 0).
- `imem_wdata` out 32: assembled word.
- `core_rst_n` out 1: active-low reset to the core; low while loading or on error.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky; cleared by `start` or `rst_n`.

## Operation
- Stream format, in order:
  - LEN_LO, then LEN_HI: 16-bit word count N.
  - 4·N payload bytes, each word LSB first.
  - Optional checksum byte (see Configuration).
- States:
  - IDLE: `start` → LEN_LO; `start` also clears `error`, the byte counter (0..3) and the word index.
  - LEN_LO: transfer → LEN_HI.
  - LEN_HI: transfer → DATA if 1 ≤ N ≤ MAX_WORDS, else ERR.
  - DATA: each transfer shifts the byte into lane `byte_cnt` (lane 0 = bits [7:0]). When the 4th byte is accepted, the word is registered and the write issues; word index increments after the write. When the last word is written → CHK if enabled, else DONE.
  - CHK: transfer → DONE if the checksum matches, else ERR.
  - DONE: one cycle; `done`=1, then → IDLE.
  - ERR: `error` set; → IDLE next cycle.
- `imem_waddr` = word_index << 2. Word index width is clog2(MAX_WORDS)+1 and never wraps, because N ≤ MAX_WORDS.
- `core_rst_n`:
  - Low from the cycle after `start` is accepted until the cycle after DONE.
  - After ERR it stays low until a later load succeeds.
- `start` while busy: ignored. `byte_valid` in IDLE: not accepted.
- Source stalls (`byte_valid`=0) may last any length; no timeout.

## Timing
- Reset values: `byte_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `core_rst_n`=0, `busy`=0, `done`=0, `error`=0, state IDLE, counters 0.
- `core_rst_n` rises to 1 in the first cycle after `rst_n` deasserts, provided no `start` is present.
- `byte_ready` is a registered output: it is 1 in the cycle after entering LEN_LO and stays 1 through LEN_HI/DATA/CHK. There is no backpressure from the write port; the memory accepts a write every cycle.
- Write latency: `imem_we` asserts the cycle after the 4th byte of a word is accepted. Back-to-back bytes therefore give one write per 4 cycles.
- DONE follows one cycle after the last `imem_we`. `done` and the `core_rst_n` rise occur in the same cycle.
- `rst_n` low mid-load: abort immediately, with all outputs at reset values next edge. Partially written memory is not cleared.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN`:
  - Defined: the loader keeps an 8-bit XOR of all payload bytes (length bytes excluded) and expects one trailing byte equal to it. A mismatch → ERR. The memory is already written, but `core_rst_n` stays low.
  - Undefined: there is no CHK state, and DATA goes directly to DONE.

## Structure
- `imem_loader_pkg`:
  - state enum `loader_state_e` (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR);
  - constant `IMEM_WORDS` = 1024;
  - constant `NOP_INSTR` = 32'h00000013, for bench fill checks.
- One sub-module: `byte_word_assembler`. It holds the 2-bit lane counter and a 32-bit shift register, and emits `word_valid` plus `word` on the 4th byte. The FSM and address/length logic stay in `imem_loader`.

## Test plan
- Load N=2, bytes 02 00 | 93 00 50 00 | 13 01 A0 00:
  - writes 0x00500093 @0x0, then 0x00A00113 @0x4;
  - `done` pulse;
  - `core_rst_n` low → high.
- Length 0 (00 00) → `error`=1, no `imem_we`, `core_rst_n` stays 0. A following valid `start` + load clears `error`.
- Length MAX_WORDS+1 (01 04) → ERR immediately after LEN_HI; zero writes.
- Random `byte_valid` gaps of 0–7 cycles on an 8-word image → identical writes and addresses as the gap-free run; `imem_we` count = 8.
- `start` pulsed during DATA is ignored. `rst_n` low after word 1 → all outputs reset next edge. A reload from `start` succeeds.
- With `IMEM_LOADER_CHECKSUM_EN`:
  - image 93 00 50 00, checksum C3 → `done`;
  - checksum C2 → `error`, `core_rst_n`=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_e;

  localparam int          IMEM_WORDS = 1024;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader; master is the loader side.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_word_assembler.sv
// Packs accepted bytes LSB-first into 32-bit words; word_valid pulses the cycle after the 4th byte.
// No backpressure of its own: every byte_fire is consumed.
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_fire,
  input  logic [7:0]  byte_data,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane       <= 2'd0;
      shreg      <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= 2'd0;
      end else if (byte_fire) begin
        shreg <= {byte_data, shreg[23:8]};
        lane  <= lane + 2'd1;
        if (lane == 2'd3) begin
          word       <= {byte_data, shreg};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed LE byte stream -> imem word writes from address 0, core held in reset until done.
// Write issues 1 cycle after a word's 4th byte; byte_ready registered. IMEM_LOADER_CHECKSUM_EN adds an XOR trailer byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = IMEM_WORDS,
  parameter int ADDR_W    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_rst_n,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_LEN_LO = LEN_LO;
  localparam logic [2:0] ST_LEN_HI = LEN_HI;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_CHK    = CHK;
  localparam logic [2:0] ST_DONE   = DONE;
  localparam logic [2:0] ST_ERR    = ERR;

  logic [2:0]       state, nstate;
  logic [7:0]       len_lo;
  logic [15:0]      len, len_in;
  logic [IDX_W-1:0] windex, last_idx;
  logic             ready_q, ready_d;
  logic             error_d, core_rst_d;
  logic             fire, load_start, data_fire, final_byte, last_write, len_ok;
  logic [1:0]       lane;
  logic             word_valid;
  logic [31:0]      word;

  assign fire       = bus.byte_valid && ready_q;
  assign load_start = (state == ST_IDLE) && start;
  assign data_fire  = (state == ST_DATA) && fire;
  assign len_in     = {bus.byte_data, len_lo};
  assign len_ok     = (len_in != 16'd0) && (32'(len_in) <= 32'(MAX_WORDS));
  assign last_idx   = IDX_W'(len - 16'd1);
  // windex only advances on a write, so at a word's 4th byte it still names that word.
  assign final_byte = data_fire && (lane == 2'd3) && (windex == last_idx);
  assign last_write = (state == ST_DATA) && word_valid && (windex == last_idx);

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (load_start),
    .byte_fire  (data_fire),
    .byte_data  (bus.byte_data),
    .lane       (lane),
    .word_valid (word_valid),
    .word       (word)
  );

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = word_valid;
  assign bus.imem_wdata = word;
  assign bus.imem_waddr = ADDR_W'({windex, 2'b00});
  assign busy           = (state != ST_IDLE);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_CHK;
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (!rst_n)         csum <= 8'd0;
    else if (load_start) csum <= 8'd0;
    else if (data_fire)  csum <= csum ^ bus.byte_data;
  end
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_DONE;
`endif

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:   if (start) nstate = ST_LEN_LO;
      ST_LEN_LO: if (fire)  nstate = ST_LEN_HI;
      ST_LEN_HI: if (fire)  nstate = len_ok ? ST_DATA : ST_ERR;
      ST_DATA:   if (last_write) nstate = ST_AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK:    if (fire)  nstate = (bus.byte_data == csum) ? ST_DONE : ST_ERR;
`endif
      ST_DONE:   nstate = ST_IDLE;
      ST_ERR:    nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  // Ready is computed from the next state so it never lingers into DONE/ERR/IDLE.
  always_comb begin
    ready_d = 1'b0;
    case (nstate)
      ST_LEN_LO, ST_LEN_HI, ST_CHK: ready_d = 1'b1;
      ST_DATA:                      ready_d = !final_byte;
      default:                      ready_d = 1'b0;
    endcase
  end

  always_comb begin
    error_d = error;
    if (load_start)        error_d = 1'b0;
    if (nstate == ST_ERR)  error_d = 1'b1;
    core_rst_d = ((nstate == ST_IDLE) || (nstate == ST_DONE)) && !error_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len_lo     <= 8'd0;
      len        <= 16'd0;
      windex     <= '0;
      ready_q    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      state      <= nstate;
      ready_q    <= ready_d;
      done       <= (nstate == ST_DONE);
      error      <= error_d;
      core_rst_n <= core_rst_d;
      if ((state == ST_LEN_LO) && fire) len_lo <= bus.byte_data;
      if ((state == ST_LEN_HI) && fire) len    <= len_in;
      if (load_start)      windex <= '0;
      else if (word_valid) windex <= windex + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; expected writes come from the image held in the bench.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n, start, core_rst_n, busy, done, error;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(.MAX_WORDS(IMEM_WORDS), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] img[$];
  logic [7:0]  strm[$];

  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_we_cyc = 0;
  logic        rst_at_done = 1'b0;
  logic [63:0] wr_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.imem_we === 1'b1) begin
      wr_q.push_back({bus.imem_waddr, bus.imem_wdata});
      last_we_cyc <= cyc;
    end
    if (done === 1'b1) begin
      done_cnt    <= done_cnt + 1;
      done_cyc    <= cyc;
      rst_at_done <= core_rst_n;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_byte_ready"}, bus.byte_ready, 0);
    check({tag, "_imem_we"},    bus.imem_we, 0);
    check({tag, "_imem_waddr"}, bus.imem_waddr, 0);
    check({tag, "_imem_wdata"}, bus.imem_wdata, 0);
    check({tag, "_core_rst_n"}, core_rst_n, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_error"},      error, 0);
  endtask

  // Stream = N (LE16), payload words LSB first, optional XOR trailer.
  task automatic mk_stream();
    logic [15:0] n;
    logic [7:0]  x;
    n = 16'(img.size());
    x = 8'd0;
    strm.delete();
    strm.push_back(n[7:0]);
    strm.push_back(n[15:8]);
    foreach (img[i]) begin
      for (int b = 0; b < 4; b++) begin
        strm.push_back(img[i][8*b +: 8]);
        x = x ^ img[i][8*b +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    strm.push_back(x);
`endif
  endtask

  task automatic rand_img(input int n);
    img.delete();
    img.push_back(NOP_INSTR);
    for (int i = 1; i < n; i++) img.push_back($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int from, input int to, input int maxgap);
    int gap;
    int t;
    int timeouts;
    timeouts = 0;
    for (int i = from; i < to; i++) begin
      gap = $urandom_range(maxgap, 0);
      repeat (gap) @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = strm[i];
      t = 0;
      while (bus.byte_ready !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        timeouts++;
        bus.byte_valid = 1'b0;
        break;
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
    end
    check("send_timeouts", timeouts, 0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", (t >= 400), 0);
    @(negedge clk);
  endtask

  task automatic run_load(input int maxgap, input int split, output int wbase, output int dbase);
    wbase = wr_q.size();
    dbase = done_cnt;
    pulse_start();
    check("load_busy", busy, 1);
    check("load_core_rst_n", core_rst_n, 0);
    if (split > 0) begin
      send(0, split, maxgap);
      pulse_start();
      send(split, strm.size(), maxgap);
    end else begin
      send(0, strm.size(), maxgap);
    end
    wait_idle();
  endtask

  task automatic verify_ok(input string tag, input int wbase, input int dbase);
    check({tag, "_wr_count"}, wr_q.size() - wbase, img.size());
    for (int i = 0; i < img.size() && (wbase + i) < wr_q.size(); i++) begin
      check({tag, "_waddr"}, wr_q[wbase+i][63:32], 32'(4 * i));
      check({tag, "_wdata"}, wr_q[wbase+i][31:0], img[i]);
    end
    check({tag, "_done_pulses"}, done_cnt - dbase, 1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check({tag, "_done_after_last_we"}, done_cyc, last_we_cyc + 1);
`endif
    check({tag, "_core_rst_at_done"}, rst_at_done, 1);
    check({tag, "_error"}, error, 0);
    check({tag, "_core_rst_n"}, core_rst_n, 1);
    check({tag, "_ready_idle"}, bus.byte_ready, 0);
  endtask

  initial begin
    int wb;
    int db;
    logic [15:0] over;

    rst_n = 1'b0;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_core_rst_n", core_rst_n, 1);
    check("post_reset_busy", busy, 0);

    // Directed two-word image.
    img = '{32'h00500093, 32'h00A00113};
    mk_stream();
    check("stream_byte2", strm[2], 8'h93);
    run_load(0, 0, wb, db);
    verify_ok("two_word", wb, db);

    // Zero length is rejected after LEN_HI with no writes.
    strm = '{8'h00, 8'h00};
    run_load(0, 0, wb, db);
    check("len0_error", error, 1);
    check("len0_core_rst_n", core_rst_n, 0);
    check("len0_writes", wr_q.size() - wb, 0);
    check("len0_done", done_cnt - db, 0);
    repeat (3) @(negedge clk);
    check("len0_error_sticky", error, 1);

    // One word past the memory depth.
    over = 16'(IMEM_WORDS + 1);
    strm = '{over[7:0], over[15:8]};
    wb = wr_q.size();
    db = done_cnt;
    pulse_start();
    check("start_clears_error", error, 0);
    send(0, 2, 0);
    wait_idle();
    check("over_error", error, 1);
    check("over_core_rst_n", core_rst_n, 0);
    check("over_writes", wr_q.size() - wb, 0);

    // Same 8-word image, gap-free then with random source stalls.
    rand_img(8);
    mk_stream();
    run_load(0, 0, wb, db);
    verify_ok("img8_nogap", wb, db);
    run_load(7, 0, wb, db);
    verify_ok("img8_gaps", wb, db);

    // start in the middle of DATA must not disturb the load.
    rand_img(4);
    mk_stream();
    run_load(3, 7, wb, db);
    verify_ok("start_in_data", wb, db);

    // Reset mid-load right after word 0 is written.
    rand_img(4);
    mk_stream();
    wb = wr_q.size();
    pulse_start();
    send(0, 6, 0);
    check("abort_we_word0", bus.imem_we, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("abort");
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_writes", wr_q.size() - wb, 1);
    check("abort_release_core_rst_n", core_rst_n, 1);
    rand_img(5);
    mk_stream();
    run_load(2, 0, wb, db);
    verify_ok("reload", wb, db);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img  = '{32'h00500093};
    strm = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    run_load(0, 0, wb, db);
    verify_ok("csum_good", wb, db);
    strm = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
    run_load(0, 0, wb, db);
    check("csum_bad_error", error, 1);
    check("csum_bad_core_rst_n", core_rst_n, 0);
    check("csum_bad_writes", wr_q.size() - wb, 1);
    check("csum_bad_done", done_cnt - db, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
